// File: rtl/free_list_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | free_list_if : rename-side alloc / commit-side release bundle         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface free_list_if #(
    parameter int WIDTH = 5
);
    logic [3:0]         i_allocReq;
    logic               o_allocValid;
    logic [4*WIDTH-1:0] o_allocAddr4x;
    logic [3:0]         i_freeEn;
    logic [4*WIDTH-1:0] i_freeAddr4x;
    logic [2:0]         i_commitNum;
    logic               i_flush;
    logic [WIDTH:0]     o_freeCount;
    logic               o_overflow;

    modport slave (
        input  i_allocReq, i_freeEn, i_freeAddr4x, i_commitNum, i_flush,
        output o_allocValid, o_allocAddr4x, o_freeCount, o_overflow
    );

    modport master (
        output i_allocReq, i_freeEn, i_freeAddr4x, i_commitNum, i_flush,
        input  o_allocValid, o_allocAddr4x, o_freeCount, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | free_list : 4-wide physical register free list with flush rollback    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module free_list #(
    parameter int WIDTH = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    free_list_if.slave   bus
);
    localparam int               c_SIZE      = 1 << WIDTH;
    localparam int               c_LANES     = 4;
    localparam logic [WIDTH:0]   c_MAX_COUNT = (WIDTH+1)'(c_SIZE - 1);

    logic [WIDTH-1:0] slot_q [c_SIZE];
    logic [WIDTH-1:0] head_q, chead_q, tail_q;
    logic [WIDTH-1:0] head_d, chead_d, tail_d;
    logic [WIDTH:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [2:0]         w_nreq;
    logic               w_grant;
    logic [4*WIDTH-1:0] w_allocAddr;
    logic [WIDTH-1:0]   w_off;
    logic [WIDTH-1:0]   w_outstanding;
    logic [2:0]         w_commitNum;
    logic [WIDTH-1:0]   w_commitAmt;
    logic [WIDTH-1:0]   w_restored;
    logic [WIDTH:0]     w_granted;
    logic [WIDTH:0]     w_base;
    logic [WIDTH:0]     w_space;
    logic [WIDTH:0]     w_nfree;
    logic               w_drop;
    logic [c_LANES-1:0] w_wrEn;
    logic [WIDTH-1:0]   w_wrIdx  [c_LANES];
    logic [WIDTH-1:0]   w_wrData [c_LANES];

    always_comb begin
        w_nreq = '0;
        for (int j = 0; j < c_LANES; j++) begin
            w_nreq = w_nreq + {2'b00, bus.i_allocReq[j]};
        end
        w_grant = (w_nreq != 3'd0)
               && ({{(WIDTH-2){1'b0}}, w_nreq} <= count_q)
               && !bus.i_flush;

        // Requested lanes take consecutive slots from head, lowest lane first.
        w_allocAddr = '0;
        w_off       = '0;
        for (int j = 0; j < c_LANES; j++) begin
            if (bus.i_allocReq[j]) begin
                w_allocAddr[j*WIDTH +: WIDTH] = slot_q[head_q + w_off];
                w_off = w_off + 1'b1;
            end
        end
        if (!w_grant) begin
            w_allocAddr = '0;
        end

        w_outstanding = head_q - chead_q;
        w_commitNum   = (bus.i_commitNum > 3'd4) ? 3'd4 : bus.i_commitNum;
        w_commitAmt   = ({{(WIDTH-3){1'b0}}, w_commitNum} < w_outstanding)
                      ? {{(WIDTH-3){1'b0}}, w_commitNum} : w_outstanding;
        chead_d       = chead_q + w_commitAmt;
        w_restored    = bus.i_flush ? (head_q - chead_d) : '0;

        if (bus.i_flush) begin
            head_d = chead_d;
        end else if (w_grant) begin
            head_d = head_q + {{(WIDTH-3){1'b0}}, w_nreq};
        end else begin
            head_d = head_q;
        end

        w_granted = w_grant ? {{(WIDTH-2){1'b0}}, w_nreq} : '0;
        w_base    = count_q - w_granted + {1'b0, w_restored};
        w_space   = c_MAX_COUNT - w_base;

        // Releases are compacted greedily; lanes beyond the free space are dropped.
        w_nfree = '0;
        w_drop  = 1'b0;
        for (int j = 0; j < c_LANES; j++) begin
            w_wrEn[j]   = 1'b0;
            w_wrIdx[j]  = tail_q + w_nfree[WIDTH-1:0];
            w_wrData[j] = bus.i_freeAddr4x[j*WIDTH +: WIDTH];
            if (bus.i_freeEn[j] && (w_wrData[j] != '0)) begin
                if (w_nfree < w_space) begin
                    w_wrEn[j] = 1'b1;
                    w_nfree   = w_nfree + 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end

        tail_d     = tail_q + w_nfree[WIDTH-1:0];
        count_d    = w_base + w_nfree;
        overflow_d = w_drop;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < c_SIZE - 1; k++) begin
                slot_q[k] <= WIDTH'(k + 1);
            end
            slot_q[c_SIZE-1] <= '0;
            head_q     <= '0;
            chead_q    <= '0;
            tail_q     <= WIDTH'(c_SIZE - 1);
            count_q    <= c_MAX_COUNT;
            overflow_q <= 1'b0;
        end else begin
            for (int j = 0; j < c_LANES; j++) begin
                if (w_wrEn[j]) begin
                    slot_q[w_wrIdx[j]] <= w_wrData[j];
                end
            end
            head_q     <= head_d;
            chead_q    <= chead_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_allocValid  = w_grant;
    assign bus.o_allocAddr4x = w_allocAddr;
    assign bus.o_freeCount   = count_q;
    assign bus.o_overflow    = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_free_list : directed stimulus with queued expectations per cycle   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_free_list;
    localparam int W = 5;
    localparam int c_CAP = (1 << W) - 1;

    logic clk;
    logic rst;
    int   cyc;
    logic done;
    int   errors;
    int   checks;

    free_list_if #(.WIDTH(W)) bus ();

    free_list #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic         v;
        logic [4*W-1:0] a;
    } alloc_t;

    typedef struct {
        int           cyc;
        logic [W:0]   cnt;
        logic         ovf;
    } state_t;

    alloc_t aq[$];
    state_t sq[$];
    alloc_t ae;
    state_t se;

    logic [4*W-1:0] prev_tags;
    logic [4*W-1:0] cur_tags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*W-1:0] p4(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] fen,
                         input logic [4*W-1:0] fa, input logic [2:0] cn,
                         input logic fl, input logic ev, input logic [4*W-1:0] ea);
        alloc_t e;
        @(posedge clk);
        #1;
        bus.i_allocReq   = req;
        bus.i_freeEn     = fen;
        bus.i_freeAddr4x = fa;
        bus.i_commitNum  = cn;
        bus.i_flush      = fl;
        if (req != 4'd0) begin
            e.v = ev;
            e.a = ea;
            aq.push_back(e);
        end
    endtask

    // Expected state once the inputs currently driven have been clocked in.
    task automatic exp_state(input int cnt, input logic ovf);
        state_t s;
        s.cyc = cyc + 1;
        s.cnt = (W+1)'(cnt);
        s.ovf = ovf;
        sq.push_back(s);
    endtask

    task automatic idle();
        drive(4'd0, 4'd0, '0, 3'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst              = 1'b1;
        bus.i_allocReq   = '0;
        bus.i_freeEn     = '0;
        bus.i_freeAddr4x = '0;
        bus.i_commitNum  = '0;
        bus.i_flush      = 1'b0;
        exp_state(c_CAP, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (bus.i_allocReq != 4'd0) begin
                checks++;
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL alloc_unexpected cyc=%0d got v=%0b a=%h, no expectation queued",
                             cyc, bus.o_allocValid, bus.o_allocAddr4x);
                end else begin
                    ae = aq.pop_front();
                    if (bus.o_allocValid !== ae.v || bus.o_allocAddr4x !== ae.a) begin
                        errors++;
                        $display("FAIL alloc cyc=%0d got v=%0b a=%h expected v=%0b a=%h",
                                 cyc, bus.o_allocValid, bus.o_allocAddr4x, ae.v, ae.a);
                    end
                end
            end
            if (sq.size() > 0 && sq[0].cyc <= cyc) begin
                se = sq.pop_front();
                checks++;
                if (se.cyc != cyc || bus.o_freeCount !== se.cnt || bus.o_overflow !== se.ovf) begin
                    errors++;
                    $display("FAIL state cyc=%0d(exp@%0d) got count=%0d ovf=%0b expected count=%0d ovf=%0b",
                             cyc, se.cyc, bus.o_freeCount, bus.o_overflow, se.cnt, se.ovf);
                end
            end
        end else begin
            if (aq.size() + sq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL leftover got %0d unchecked expectations, expected 0", aq.size() + sq.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        done   = 1'b0;
        rst    = 1'b1;
        bus.i_allocReq   = '0;
        bus.i_freeEn     = '0;
        bus.i_freeAddr4x = '0;
        bus.i_commitNum  = '0;
        bus.i_flush      = 1'b0;

        // Full-width grant out of reset
        do_reset();
        drive(4'hF, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(1, 2, 3, 4));
        exp_state(27, 1'b0);
        idle();

        // Sparse request, then a release that only partly fits
        do_reset();
        drive(4'b0101, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(1, 0, 2, 0));
        exp_state(29, 1'b0);
        drive(4'h0, 4'b0111, p4(1, 2, 9, 0), 3'd0, 1'b0, 1'b0, '0);
        exp_state(31, 1'b1);
        drive(4'b0001, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(3, 0, 0, 0));
        exp_state(30, 1'b0);
        idle();

        // Exhaustion and all-or-nothing denial
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(4'hF, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(4*i+1, 4*i+2, 4*i+3, 4*i+4));
        end
        exp_state(3, 1'b0);
        drive(4'hF, 4'h0, '0, 3'd0, 1'b0, 1'b0, '0);
        exp_state(3, 1'b0);
        drive(4'b0111, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(29, 30, 31, 0));
        exp_state(0, 1'b0);

        // Tag-0 release ignored; freed tags come back in FIFO order across the wrap
        drive(4'h0, 4'hF, p4(7, 0, 9, 12), 3'd0, 1'b0, 1'b0, '0);
        exp_state(3, 1'b0);
        drive(4'b0001, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(7, 0, 0, 0));
        drive(4'b0010, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(0, 9, 0, 0));
        drive(4'b1000, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(0, 0, 0, 12));
        exp_state(0, 1'b0);
        drive(4'b0001, 4'h0, '0, 3'd0, 1'b0, 1'b0, '0);
        exp_state(0, 1'b0);
        idle();

        // Flush rollback with commit in the same cycle; request in flush cycle is denied
        do_reset();
        drive(4'hF, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(1, 2, 3, 4));
        drive(4'hF, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(5, 6, 7, 8));
        exp_state(23, 1'b0);
        drive(4'hF, 4'h0, '0, 3'd4, 1'b1, 1'b0, '0);
        exp_state(27, 1'b0);
        drive(4'hF, 4'h0, '0, 3'd0, 1'b0, 1'b1, p4(5, 6, 7, 8));
        exp_state(23, 1'b0);
        idle();

        // Steady alloc/free recycling through the wrap, then release at full
        do_reset();
        prev_tags = '0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                cur_tags[j*W +: W] = W'(((4*i + j) % c_CAP) + 1);
            end
            drive(4'hF, (i > 0) ? 4'hF : 4'h0, prev_tags, 3'd0, 1'b0, 1'b1, cur_tags);
            exp_state(27, 1'b0);
            prev_tags = cur_tags;
        end
        drive(4'h0, 4'hF, prev_tags, 3'd0, 1'b0, 1'b0, '0);
        exp_state(31, 1'b0);
        drive(4'h0, 4'b0100, p4(0, 0, 5, 0), 3'd0, 1'b0, 1'b0, '0);
        exp_state(31, 1'b1);
        idle();
        exp_state(31, 1'b0);
        idle();
        idle();

        done = 1'b1;
    end
endmodule
`default_nettype wire

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the rename stage; the allocating counterpart of the busy table.
- Hands out up to 4 free physical register tags per cycle to rename. The same tags feed the busy-table set port.
- Accepts up to 4 released tags per cycle from commit.
- Supports rollback of speculative allocations on pipeline flush, using a committed-head pointer.

Parameters:
WIDTH, 5, physical register tag width; SIZE = 2^WIDTH tags, tag 0 hardwired/never allocated, capacity SIZE-1

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_allocReq  input  4  per-lane allocation request mask, lane j = bit j
o_allocValid  output  1  grant: all requested lanes served this cycle
o_allocAddr4x  output  4*WIDTH  allocated tags, lane j at [(j+1)*WIDTH-1:j*WIDTH]
i_freeEn  input  4  per-lane release enable
i_freeAddr4x  input  4*WIDTH  released tags, same packing
i_commitNum  input  3  number (0..4) of oldest outstanding allocations retired this cycle
i_flush  input  1  discard all uncommitted allocations
o_freeCount  output  WIDTH+1  entries currently in list
o_overflow  output  1  one-cycle pulse: a release was dropped because the list was full

Behaviour:
- Storage: circular array of SIZE slots of WIDTH bits, plus the following registers:
  - head: speculative read pointer
  - chead: committed head
  - tail: write pointer
  - count
  - All pointers mod SIZE.
- Reset (i_rst=1 at edge, overrides everything):
  - slot k = k+1 for k=0..SIZE-2
  - head=chead=0, tail=SIZE-1, count=SIZE-1
  - o_overflow=0
- Alloc, combinational same cycle (latency 0):
  - nreq = popcount(i_allocReq).
  - o_allocValid = (nreq != 0) && (nreq <= count) && !i_flush.
  - Requested lanes receive consecutive entries from head in ascending lane order: lowest requested lane gets slot[head], next gets slot[head+1], etc.
  - Unrequested lanes, and all lanes when o_allocValid=0, drive 0.
  - All-or-nothing: no partial grant.
  - On edge with o_allocValid=1: head += nreq, count -= nreq.
- Release:
  - Lanes with i_freeEn=1 and tag != 0 are compacted and written at tail, tail+1, ... in ascending lane order.
  - tail += nfree. Tag 0 releases are silently ignored.
  - Frees are not bypassed to alloc: a tag freed at edge N is allocatable from cycle N+1.
  - If count_after_alloc + nfree > SIZE-1: accept only the lowest lanes that fit, drop the rest, pulse o_overflow for one cycle.
- Commit:
  - outstanding = (head - chead) mod SIZE.
  - chead += min(i_commitNum, outstanding). Values above 4 are treated as 4.
  - Applied before flush in the same cycle.
- Flush:
  - head <= chead (the chead value after this cycle's commit).
  - count += remaining outstanding.
  - No allocation occurs in the flush cycle.
  - Releases in the flush cycle are still accepted, and counted in the overflow check.
- Count update:
  - Next count = count - granted + restored + nfree_accepted.
  - Invariant: count == (tail - head) mod SIZE, except when full (count = SIZE-1 uses SIZE-1 slots; one slot always unused).
- o_freeCount is the registered count.
- Simultaneous alloc + release + commit in one cycle: all apply; grant decision uses the pre-edge count only.
- Wrap-around: all pointer arithmetic is modulo SIZE; lane address slot index = (head + k) mod SIZE.

Test Plan:
1. Reset, then i_allocReq=1111 -> o_allocValid=1, lanes 0..3 = 1,2,3,4; next cycle o_freeCount=27.
2. After reset, i_allocReq=0101 -> lane0=1, lane2=2, lanes1,3=0; o_freeCount=29.
3. Exhaustion:
   - Seven 1111 grants leave count=3.
   - 1111 -> o_allocValid=0, all lanes 0, count unchanged.
   - Then 0111 -> grant with lanes 0..2 = 29,30,31; count=0.
4. From count=0, free lanes {7,0,9,12} with i_freeEn=1111 -> tag 0 ignored, count=3; next three single-lane allocs return 7,9,12 in order.
5. Flush rollback:
   - After reset, allocate 1111 twice (tags 1..8).
   - i_commitNum=4 and i_flush=1 same cycle -> count=27, head back at tag 5.
   - Next 1111 alloc returns 5,6,7,8.
6. Wrap: repeated alloc/free cycles until head passes slot SIZE-1 -> returned tags continue in FIFO order across the wrap; release at full list (count=31) -> o_overflow pulses 1 cycle, count stays 31.
